// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a two-writer register file, with an issue scoreboard
// that stalls decode on RAW/WAW hazards against pending writes.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_req,
  input  logic [3:0]  alu_addr,
  input  logic [15:0] alu_data,
  output logic        alu_grant,
  input  logic        mem_req,
  input  logic [3:0]  mem_addr,
  input  logic [15:0] mem_data,
  output logic        mem_grant,
  output logic        write_en,
  output logic [3:0]  addr_w,
  output logic [15:0] data_w,
  input  logic        issue_valid,
  input  logic [3:0]  issue_src1,
  input  logic [3:0]  issue_src2,
  input  logic [3:0]  issue_dst,
  output logic        stall,
  output logic [15:0] busy
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_next;
  logic          alu_priority;
  logic          any_grant;
  logic [3:0]    win_addr;
  logic [15:0]   win_data;
  logic          wb_fire;
  logic          issue_accept;
  logic [15:0]  set_mask;
  logic [15:0]  clr_mask;
  logic [15:0]  busy_next;

  // Mem wins by default; a starved ALU requester takes the port once.
  always_comb begin
    alu_priority = (starve_cnt == LIMIT);
    alu_grant    = alu_req & (~mem_req | alu_priority);
    mem_grant    = mem_req & ~alu_grant;
    any_grant    = alu_grant | mem_grant;
    win_addr     = alu_grant ? alu_addr : mem_addr;
    win_data     = alu_grant ? alu_data : mem_data;
    wb_fire      = any_grant & (win_addr != 4'd0);
  end

  always_comb begin
    starve_next = '0;
    if (alu_req && !alu_grant) begin
      starve_next = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_next;
    end
  end

  // Write port: addr/data hold when nothing is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_en <= 1'b0;
      addr_w   <= 4'd0;
      data_w   <= 16'd0;
    end else begin
      write_en <= wb_fire;
      if (wb_fire) begin
        addr_w <= win_addr;
        data_w <= win_data;
      end
    end
  end

  always_comb begin
    stall        = issue_valid & (busy[issue_src1] | busy[issue_src2] | busy[issue_dst]);
    issue_accept = issue_valid & ~stall;
    set_mask     = '0;
    clr_mask     = '0;
    if (issue_accept && issue_dst != 4'd0) begin
      set_mask = 16'h0001 << issue_dst;
    end
    if (write_en) begin
      clr_mask = 16'h0001 << addr_w;
    end
    // Set is applied after clear so a same-cycle reissue keeps the bit.
    busy_next = ((busy & ~clr_mask) | set_mask) & 16'hFFFE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 16'd0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: consecutive lost arbitration cycles after which ALU requester gets priority.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 alu_req  input  1  ALU writeback request.
REQ-005 alu_addr  input  4  ALU destination register.
REQ-006 alu_data  input  16  ALU writeback data.
REQ-007 alu_grant  output  1  ALU request accepted this cycle (combinational).
REQ-008 mem_req  input  1  load writeback request.
REQ-009 mem_addr  input  4  load destination register.
REQ-010 mem_data  input  16  load writeback data.
REQ-011 mem_grant  output  1  load request accepted this cycle (combinational).
REQ-012 write_en  output  1  register-file write enable, registered.
REQ-013 addr_w  output  4  register-file write address, registered.
REQ-014 data_w  output  16  register-file write data, registered.
REQ-015 issue_valid  input  1  decode stage issuing an instruction.
REQ-016 issue_src1, issue_src2, issue_dst  input  4 each  issuing instruction's sources and destination.
REQ-017 stall  output  1  issue blocked by pending write (combinational).
REQ-018 busy  output  16  scoreboard, bit n = write to register n pending, registered.

Function
REQ-019 At most one grant per cycle; a requester is granted only if its req is high.
REQ-020 Default priority: mem over alu.
REQ-021 starve_cnt (width ceil(log2(STARVE_LIMIT+1))): increments, saturating at STARVE_LIMIT, when alu_req high and alu not granted; clears when alu granted or alu_req low.
REQ-022 When starve_cnt == STARVE_LIMIT and both requests high, alu is granted, mem is not.
REQ-023 Granted request is captured at next rising edge: write_en=1, addr_w/data_w = winner's addr/data; no grant -> write_en=0, addr_w/data_w hold.
REQ-024 Latency: request granted in cycle N appears on write port in cycle N+1, held the full cycle.
REQ-025 Granted request with addr 0 is consumed (grant high) but produces write_en=0 next cycle; register 0 is never written.
REQ-026 Issue accepted when issue_valid=1 and stall=0.
REQ-027 stall = issue_valid & (busy[issue_src1] | busy[issue_src2] | busy[issue_dst]); WAW blocked as well as RAW.
REQ-028 Accepted issue with issue_dst != 0 sets busy[issue_dst] at next edge; issue_dst == 0 sets nothing.
REQ-029 write_en=1 clears busy[addr_w] at next edge.
REQ-030 Same-register set and clear in one cycle: set wins (busy stays 1).
REQ-031 Writeback to a register whose busy bit is 0 is still performed; no error flag.
REQ-032 busy[0] is constant 0.
REQ-033 No pipeline bypass: a source cleared this cycle stalls until busy bit drops at the edge.

Reset
REQ-034 rst=1 at rising edge: write_en=0, addr_w=0, data_w=0, busy=0, starve_cnt=0.
REQ-035 During rst, grants and stall are evaluated normally, but requests granted in a reset cycle are dropped and not written.
REQ-036 Reset asserted mid-operation discards all pending scoreboard state; first post-reset cycle behaves as idle.

Verification
REQ-037 Both req same cycle, mem_addr=3/0x00AA, alu_addr=5/0x0055, starve_cnt=0 -> mem_grant=1, alu_grant=0; next cycle write_en=1, addr_w=3, data_w=0x00AA.
REQ-038 alu_req and mem_req both held high 4 cycles, STARVE_LIMIT=3 -> mem granted cycles 0-2, alu granted cycle 3, starve_cnt back to 0.
REQ-039 Issue dst=4, then next cycle issue src1=4 -> stall=1 until writeback to r4 has write_en=1; cycle after, busy[4]=0 and stall=0.
REQ-040 alu_req addr=0 data=0xFFFF -> alu_grant=1; next cycle write_en=0, busy unchanged.
REQ-041 Writeback to r7 (write_en=1, addr_w=7) coincides with accepted issue dst=7 -> busy[7]=1 after edge.
REQ-042 busy=0x00F0, write pending, rst=1 one cycle -> busy=0, write_en=0, addr_w=0, data_w=0.
